// File: rtl/mont_pkg.sv
// mont_pkg: shared types and default widths for the Montgomery datapath.
//   mult_state_t : control states of mont_operand_multiplier
//   red_state_t  : control states of the downstream bit-serial reducer
//   OP_W_DEF     : default operand/modulus width
//   PROD_W_DEF   : default product width (reducer x/m width)
package mont_pkg;

  localparam int unsigned OP_W_DEF   = 32;
  localparam int unsigned PROD_W_DEF = 2 * OP_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  typedef enum logic [1:0] {
    RED_IDLE  = 2'd0,
    RED_SHIFT = 2'd1,
    RED_FINAL = 2'd2,
    RED_DONE  = 2'd3
  } red_state_t;

endpackage

// File: rtl/mont_operand_multiplier_if.sv
// mont_operand_multiplier_if: request/result bundle of the operand multiplier.
//   Request side : start_i, a_i, b_i, m_i (to DUT), ready_o (from DUT)
//   Result side  : product_o, m_o, err_o, valid_o (from DUT), ack_i (to DUT)
//   slave  modport: seen by the multiplier
//   master modport: seen by the requester/consumer
interface mont_operand_multiplier_if
  import mont_pkg::*;
#(
  parameter int unsigned OP_W   = OP_W_DEF,
  parameter int unsigned PROD_W = PROD_W_DEF
);

  logic              start_i;
  logic [OP_W-1:0]   a_i;
  logic [OP_W-1:0]   b_i;
  logic [OP_W-1:0]   m_i;
  logic              ready_o;
  logic [PROD_W-1:0] product_o;
  logic [PROD_W-1:0] m_o;
  logic              err_o;
  logic              valid_o;
  logic              ack_i;

  modport slave (
    input  start_i, a_i, b_i, m_i, ack_i,
    output ready_o, product_o, m_o, err_o, valid_o
  );

  modport master (
    output start_i, a_i, b_i, m_i, ack_i,
    input  ready_o, product_o, m_o, err_o, valid_o
  );

endinterface

// File: rtl/mont_operand_multiplier.sv
// mont_operand_multiplier: serial radix-2 shift-and-add multiplier feeding the
// bit-serial Montgomery reducer. Computes a*b (full PROD_W width) one
// multiplier bit per cycle, fixed OP_W-cycle latency, and presents it with a
// latched, zero-extended copy of the modulus.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : slave side of mont_operand_multiplier_if
//             start_i/ready_o request handshake (a_i, b_i, m_i operands)
//             valid_o/ack_i result handshake (product_o, m_o, err_o)
module mont_operand_multiplier
  import mont_pkg::*;
#(
  parameter int unsigned OP_W   = OP_W_DEF,
  parameter int unsigned PROD_W = PROD_W_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  mont_operand_multiplier_if.slave   bus
);

  localparam int unsigned CNT_W = (OP_W > 1) ? $clog2(OP_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

  mult_state_t       state_q, state_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [OP_W-1:0]   mplr_q, mplr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   m_q, m_d;
  logic              err_q, err_d;
  logic [PROD_W-1:0] product_q, product_d;
  logic [PROD_W-1:0] acc_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      m_q       <= '0;
      err_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      err_q     <= err_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    err_d     = err_q;
    product_d = product_q;
    // a*b < 2^PROD_W, so the accumulate never carries out.
    acc_next  = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          mcand_d = PROD_W'(bus.a_i);
          mplr_d  = bus.b_i;
          m_d     = bus.m_i;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = (bus.a_i >= bus.m_i) | (bus.b_i >= bus.m_i);
          state_d = MULT;
        end
      end
      MULT: begin
        acc_d   = acc_next;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          product_d = acc_next;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready_o   = (state_q == IDLE);
  assign bus.valid_o   = (state_q == DONE);
  assign bus.product_o = product_q;
  assign bus.m_o       = PROD_W'(m_q);
  assign bus.err_o     = err_q;

endmodule
